// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX memory responder: FSM states and MMIO map.
package dlx_mem_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   localparam logic [3:0]  MMIO_TAG   = 4'hF;
   localparam logic [31:0] MMIO_CYCLE = 32'hF000_0000;
   localparam logic [31:0] MMIO_HALT  = 32'hF000_0004;
   localparam logic [31:0] MMIO_DBG   = 32'hF000_0008;

endpackage

// File: rtl/dlx_sync_ram.sv
// Single-port-write, registered-read RAM; read-first on a same-address collision.
module dlx_sync_ram #(
   parameter int W  = 32,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [2**AW];
   logic [W-1:0] rdata_q;

   // Array has no reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dlx_mem_responder.sv
// Program loader, instruction/data memories and MMIO block for a DLX core.
module dlx_mem_responder
   import dlx_mem_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int INST_ADDR_WIDTH = 20,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int IMEM_AW         = 10,
   parameter int DMEM_AW         = 10,
   parameter logic [INST_ADDR_WIDTH-1:0] PC_INITIAL_ADDRESS = 20'h40000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       instr_rd_en,
   input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
   output logic [DATA_WIDTH-1:0]      instruction,
   input  logic                       data_rd_en,
   input  logic                       data_wr_en,
   input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0]      data_write,
   output logic [DATA_WIDTH-1:0]      data_read,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [DATA_WIDTH-1:0]      ld_data,
   input  logic                       ld_last,
   output logic                       core_rst_n,
   output logic                       halted,
   output logic                       dbg_valid,
   output logic [DATA_WIDTH-1:0]      dbg_data
);

   state_e                       state_q, state_d;
   logic [IMEM_AW-1:0]           load_ptr_q;
   logic [31:0]                  cycle_q;
   logic                         core_rst_n_q, halted_q, dbg_valid_q;
   logic [DATA_WIDTH-1:0]        dbg_data_q, mmio_rdata_q;
   logic                         dsel_mmio_q, ioor_q;

   logic                         run, ld_fire, mmio, d_rd, d_wr, i_rd, i_oor;
   logic [INST_ADDR_WIDTH-1:0]   i_diff;
   logic [DATA_WIDTH-1:0]        imem_rdata, dmem_rdata;
   logic                         unused_idiff;

   assign run      = (state_q == ST_RUN);
   assign ld_ready = (state_q == ST_LOAD) && !rst;
   assign ld_fire  = ld_valid && ld_ready;
   assign mmio     = (data_addr[DATA_ADDR_WIDTH-1 -: 4] == MMIO_TAG);
   assign d_rd     = run && data_rd_en && !rst;
   assign d_wr     = run && data_wr_en && !rst;
   assign i_rd     = run && instr_rd_en && !rst;

   // Fetches below the base or past the array depth read as zero.
   assign i_diff       = instr_addr - PC_INITIAL_ADDRESS;
   assign i_oor        = (instr_addr < PC_INITIAL_ADDRESS) ||
                         (|i_diff[INST_ADDR_WIDTH-1:IMEM_AW+2]);
   assign unused_idiff = ^i_diff[1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (ld_fire && (ld_last || (&load_ptr_q))) state_d = ST_RUN;
         ST_RUN:  if (d_wr && data_addr == DATA_ADDR_WIDTH'(MMIO_HALT)) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         load_ptr_q   <= '0;
         cycle_q      <= '0;
         core_rst_n_q <= 1'b0;
         halted_q     <= 1'b0;
         dbg_valid_q  <= 1'b0;
         dbg_data_q   <= '0;
         mmio_rdata_q <= '0;
         dsel_mmio_q  <= 1'b0;
         ioor_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         core_rst_n_q <= (state_d == ST_RUN);
         halted_q     <= (state_d == ST_HALT);
         dbg_valid_q  <= d_wr && (data_addr == DATA_ADDR_WIDTH'(MMIO_DBG));
         if (ld_fire) load_ptr_q <= load_ptr_q + 1'b1;
         if (run) cycle_q <= cycle_q + 32'd1;
         if (d_wr && data_addr == DATA_ADDR_WIDTH'(MMIO_DBG)) dbg_data_q <= data_write;
         if (i_rd) ioor_q <= i_oor;
         // The read source is remembered so data_read holds with the last read.
         if (d_rd) begin
            dsel_mmio_q  <= mmio;
            mmio_rdata_q <= (data_addr == DATA_ADDR_WIDTH'(MMIO_CYCLE)) ?
                            DATA_WIDTH'(cycle_q) : '0;
         end
      end
   end

   dlx_sync_ram #(.W(DATA_WIDTH), .AW(IMEM_AW)) u_imem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ld_fire),
      .waddr_i (load_ptr_q),
      .wdata_i (ld_data),
      .re_i    (i_rd),
      .raddr_i (i_diff[IMEM_AW+1:2]),
      .rdata_o (imem_rdata)
   );

   dlx_sync_ram #(.W(DATA_WIDTH), .AW(DMEM_AW)) u_dmem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (d_wr && !mmio),
      .waddr_i (data_addr[DMEM_AW+1:2]),
      .wdata_i (data_write),
      .re_i    (d_rd && !mmio),
      .raddr_i (data_addr[DMEM_AW+1:2]),
      .rdata_o (dmem_rdata)
   );

   assign instruction = ioor_q ? '0 : imem_rdata;
   assign data_read   = dsel_mmio_q ? mmio_rdata_q : dmem_rdata;
   assign core_rst_n  = core_rst_n_q;
   assign halted      = halted_q;
   assign dbg_valid   = dbg_valid_q;
   assign dbg_data    = dbg_data_q;

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Directed bench for dlx_mem_responder: load, fetch, data RAM, MMIO, halt and reset.
module tb_dlx_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_rd_en;
   logic [19:0] instr_addr;
   logic [31:0] instruction;
   logic        data_rd_en, data_wr_en;
   logic [31:0] data_addr, data_write, data_read;
   logic        ld_valid, ld_ready, ld_last;
   logic [31:0] ld_data;
   logic        core_rst_n, halted, dbg_valid;
   logic [31:0] dbg_data;

   int          checks = 0;
   int          errors = 0;
   logic        m_run  = 1'b0;
   logic [31:0] m_cnt  = 32'd0;
   logic [31:0] exp_cnt;

   localparam logic [31:0] WA = 32'h0A0A_0001;
   localparam logic [31:0] WB = 32'h0B0B_0002;
   localparam logic [31:0] WC = 32'h0C0C_0003;
   localparam logic [31:0] WD = 32'h0D0D_0004;

   dlx_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .instr_rd_en (instr_rd_en),
      .instr_addr  (instr_addr),
      .instruction (instruction),
      .data_rd_en  (data_rd_en),
      .data_wr_en  (data_wr_en),
      .data_addr   (data_addr),
      .data_write  (data_write),
      .data_read   (data_read),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .core_rst_n  (core_rst_n),
      .halted      (halted),
      .dbg_valid   (dbg_valid),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   // One clock edge; the counter model advances on edges that close a RUN cycle.
   task automatic tick();
      @(posedge clk);
      if (m_run) m_cnt = m_cnt + 32'd1;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; instr_rd_en = 1'b0; instr_addr = '0;
      data_rd_en = 1'b0; data_wr_en = 1'b0; data_addr = '0; data_write = '0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      tick(); tick();
      chk("rst_instruction", instruction, 32'h0);
      chk("rst_data_read",   data_read,   32'h0);
      chk("rst_dbg_valid",   {31'b0, dbg_valid},  32'h0);
      chk("rst_dbg_data",    dbg_data,    32'h0);
      chk("rst_halted",      {31'b0, halted},     32'h0);
      chk("rst_core_rst_n",  {31'b0, core_rst_n}, 32'h0);
      chk("rst_ld_ready",    {31'b0, ld_ready},   32'h0);
      rst = 1'b0; #1;
      chk("post_rst_ld_ready", {31'b0, ld_ready}, 32'h1);

      // Partial load of 2 words, then reset with a word still offered.
      ld_valid = 1'b1; ld_data = 32'h1111_1111; tick();
      ld_data = 32'h2222_2222; tick();
      chk("midload_core_rst_n", {31'b0, core_rst_n}, 32'h0);
      rst = 1'b1; ld_data = 32'h9999_9999; tick();
      chk("midload_rst_core_rst_n", {31'b0, core_rst_n}, 32'h0);
      chk("midload_rst_ld_ready",   {31'b0, ld_ready},   32'h0);
      rst = 1'b0;
      ld_data = WA; tick();
      ld_data = WB; tick();
      chk("load_before_last_core_rst_n", {31'b0, core_rst_n}, 32'h0);
      ld_data = WC; ld_last = 1'b1; tick();
      m_run = 1'b1;
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("load_done_core_rst_n", {31'b0, core_rst_n}, 32'h1);
      chk("load_done_ld_ready",   {31'b0, ld_ready},   32'h0);
      chk("load_done_halted",     {31'b0, halted},     32'h0);

      // Instruction fetch, stall hold and out-of-range addresses.
      instr_rd_en = 1'b1; instr_addr = 20'h40000; tick();
      chk("fetch_w0", instruction, WA);
      instr_addr = 20'h40004; tick();
      chk("fetch_w1", instruction, WB);
      instr_rd_en = 1'b0; instr_addr = 20'h40008;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fetch_stall_hold", instruction, WB);
      end
      instr_rd_en = 1'b1; instr_addr = 20'h3FFFC; tick();
      chk("fetch_below_base", instruction, 32'h0);
      instr_addr = 20'h40008; tick();
      chk("fetch_w2", instruction, WC);
      instr_addr = 20'h41000; tick();
      chk("fetch_beyond_depth", instruction, 32'h0);
      instr_addr = 20'h40008; tick();
      chk("fetch_w2_again", instruction, WC);
      instr_rd_en = 1'b0;

      // Data RAM: read-first collision, then new data, hold, aliasing.
      data_wr_en = 1'b1; data_addr = 32'h10; data_write = 32'h1234_5678; tick();
      data_rd_en = 1'b1; data_write = 32'hDEAD_BEEF; tick();
      chk("dmem_read_first", data_read, 32'h1234_5678);
      data_wr_en = 1'b0; tick();
      chk("dmem_read_after_write", data_read, 32'hDEAD_BEEF);
      data_rd_en = 1'b0; data_wr_en = 1'b1; data_addr = 32'h20; data_write = 32'hCAFE_0001; tick();
      chk("dmem_hold", data_read, 32'hDEAD_BEEF);
      data_wr_en = 1'b0; data_rd_en = 1'b1; data_addr = 32'h0000_1023; tick();
      chk("dmem_alias_offset", data_read, 32'hCAFE_0001);
      data_rd_en = 1'b0;

      // MMIO debug strobe, cycle counter, unmapped read.
      data_wr_en = 1'b1; data_addr = 32'hF000_0008; data_write = 32'h55; tick();
      chk("dbg_valid_set", {31'b0, dbg_valid}, 32'h1);
      chk("dbg_data_set",  dbg_data,  32'h55);
      data_wr_en = 1'b0; tick();
      chk("dbg_valid_one_cycle", {31'b0, dbg_valid}, 32'h0);
      chk("dbg_data_hold",       dbg_data,  32'h55);
      data_rd_en = 1'b1; data_addr = 32'hF000_0000; exp_cnt = m_cnt; tick();
      chk("mmio_cycle_count", data_read, exp_cnt);
      data_addr = 32'hF000_000C; tick();
      chk("mmio_unmapped_read", data_read, 32'h0);
      data_addr = 32'h10; tick();
      chk("dmem_after_mmio", data_read, 32'hDEAD_BEEF);
      data_rd_en = 1'b0;

      // Halt, then confirm requests are ignored.
      data_wr_en = 1'b1; data_addr = 32'hF000_0004; data_write = 32'h1; tick();
      m_run = 1'b0;
      chk("halt_halted",     {31'b0, halted},     32'h1);
      chk("halt_core_rst_n", {31'b0, core_rst_n}, 32'h0);
      chk("halt_ld_ready",   {31'b0, ld_ready},   32'h0);
      data_addr = 32'h10; data_write = 32'hBAD0_BAD0; tick();
      data_wr_en = 1'b0; data_rd_en = 1'b1; data_addr = 32'h20;
      instr_rd_en = 1'b1; instr_addr = 20'h40000; tick();
      chk("halt_data_read_hold",   data_read,   32'hDEAD_BEEF);
      chk("halt_instruction_hold", instruction, WC);
      data_rd_en = 1'b0; instr_rd_en = 1'b0;

      // Reset out of HALT, reload one word, check counter restart and preserved memories.
      rst = 1'b1; tick();
      chk("rst2_halted",      {31'b0, halted},     32'h0);
      chk("rst2_instruction", instruction, 32'h0);
      chk("rst2_data_read",   data_read,   32'h0);
      rst = 1'b0; m_cnt = 32'd0;
      ld_valid = 1'b1; ld_data = WD; ld_last = 1'b1; tick();
      m_run = 1'b1;
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("reload_core_rst_n", {31'b0, core_rst_n}, 32'h1);
      data_rd_en = 1'b1; data_addr = 32'hF000_0000; exp_cnt = m_cnt; tick();
      chk("reload_cycle_restart", data_read, exp_cnt);
      data_addr = 32'h10; tick();
      chk("halt_write_ignored", data_read, 32'hDEAD_BEEF);
      data_rd_en = 1'b0;
      instr_rd_en = 1'b1; instr_addr = 20'h40004; tick();
      chk("imem_kept_w1", instruction, WB);
      instr_addr = 20'h40000; tick();
      chk("reload_w0", instruction, WD);
      instr_rd_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
